// File: rtl/img_sram_pkg.sv
// Shared types for the image SRAM port and the transmit controller.
//   img_sram_ctrl_t : SRAM control bundle (sense_en, write_en, row, col, din)
//   tx_state_t      : transmit controller FSM states
package img_sram_pkg;

    localparam int unsigned IMG_DIM_W = 8;
    localparam int unsigned IMG_PIX_W = 8;

    typedef struct packed {
        logic                 sense_en;
        logic                 write_en;
        logic [IMG_DIM_W-1:0] row;
        logic [IMG_DIM_W-1:0] col;
        logic [IMG_PIX_W-1:0] din;
    } img_sram_ctrl_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/tx_skid_fifo.sv
// Small output FIFO that absorbs the SRAM read latency ahead of the tx port.
//   clk_i, rst_i    : clock, synchronous active-high reset (flushes contents)
//   push_i          : write push_data_i into the tail
//   push_data_i     : entry payload
//   pop_i           : drop the head entry
//   head_o          : current head entry
//   count_o         : number of stored entries (0..DEPTH)
module tx_skid_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 9
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             push_i,
    input  logic [WIDTH-1:0]                 push_data_i,
    input  logic                             pop_i,
    output logic [WIDTH-1:0]                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]       count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage, pointers and occupancy; push and pop may coincide at full.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/io_tx_controller.sv
// Streams a stored frame out of the image SRAM in raster order over a
// valid/ready byte port, using a 2-entry buffer to hide SRAM read latency.
//   clk, rst       : clock, synchronous active-high reset
//   start          : begin a frame (sampled in IDLE only)
//   nrows, ncols   : last row / last column index of the frame
//   sram_dout      : SRAM read data, one cycle after the issued address
//   sram_ctrl      : SRAM control bundle (read-only use)
//   busy, done     : frame in progress / one-cycle completion pulse
//   tx_data, tx_valid, tx_ready, tx_last : byte stream handshake
module io_tx_controller
    import img_sram_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [IMG_DIM_W-1:0] nrows,
    input  logic [IMG_DIM_W-1:0] ncols,
    input  logic [IMG_PIX_W-1:0] sram_dout,
    output img_sram_ctrl_t       sram_ctrl,
    output logic                 busy,
    output logic                 done,
    output logic [IMG_PIX_W-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 tx_last
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH+1);

    tx_state_t            state_q, state_d;
    logic [IMG_DIM_W-1:0] nrows_q, nrows_d, ncols_q, ncols_d;
    logic [IMG_DIM_W-1:0] row_q, row_d, col_q, col_d;           // next address to issue
    logic [IMG_DIM_W-1:0] lrow_q, lrow_d, lcol_q, lcol_d;       // last address issued
    logic                 inflight_q, inflight_d;
    logic                 inflight_last_q, inflight_last_d;

    logic [IMG_PIX_W:0]   fifo_head;
    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W-1:0]     credit;
    logic                 tx_hs;
    logic                 issue;
    logic                 at_last_addr;

    tx_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (IMG_PIX_W + 1)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (inflight_q),
        .push_data_i ({inflight_last_q, sram_dout}),
        .pop_i       (tx_hs),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign tx_valid = (fifo_count != '0);
    assign tx_hs    = tx_valid && tx_ready;
    assign tx_data  = tx_valid ? fifo_head[IMG_PIX_W-1:0] : '0;
    assign tx_last  = tx_valid && fifo_head[IMG_PIX_W];
    assign busy     = (state_q == READ) || (state_q == DRAIN);
    assign done     = (state_q == DONE);

    // A pop in the same cycle frees a slot, so a full credit can still issue.
    assign credit       = fifo_count + CNT_W'(inflight_q);
    assign at_last_addr = (row_q == nrows_q) && (col_q == ncols_q);
    assign issue        = (state_q == READ) &&
                          ((credit < CNT_W'(FIFO_DEPTH)) ||
                           ((credit == CNT_W'(FIFO_DEPTH)) && tx_hs));

    // Address bus shows the issued address, otherwise holds the last one.
    always_comb begin
        sram_ctrl          = '0;
        sram_ctrl.sense_en = issue;
        sram_ctrl.write_en = 1'b0;
        sram_ctrl.din      = '0;
        sram_ctrl.row      = issue ? row_q : lrow_q;
        sram_ctrl.col      = issue ? col_q : lcol_q;
    end

    // Next-state, frame size latch and raster address counters.
    always_comb begin
        state_d         = state_q;
        nrows_d         = nrows_q;
        ncols_d         = ncols_q;
        row_d           = row_q;
        col_d           = col_q;
        lrow_d          = lrow_q;
        lcol_d          = lcol_q;
        inflight_d      = issue;
        inflight_last_d = issue && at_last_addr;

        case (state_q)
            IDLE: begin
                row_d  = '0;
                col_d  = '0;
                lrow_d = '0;
                lcol_d = '0;
                if (start) begin
                    nrows_d = nrows;
                    ncols_d = ncols;
                    state_d = READ;
                end
            end
            READ: begin
                if (issue) begin
                    lrow_d = row_q;
                    lcol_d = col_q;
                    if (col_q == ncols_q) begin
                        col_d = '0;
                        row_d = row_q + IMG_DIM_W'(1);
                    end else begin
                        col_d = col_q + IMG_DIM_W'(1);
                    end
                    if (at_last_addr) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (tx_hs && tx_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                row_d   = '0;
                col_d   = '0;
                lrow_d  = '0;
                lcol_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            nrows_q         <= '0;
            ncols_q         <= '0;
            row_q           <= '0;
            col_q           <= '0;
            lrow_q          <= '0;
            lcol_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            nrows_q         <= nrows_d;
            ncols_q         <= ncols_d;
            row_q           <= row_d;
            col_q           <= col_d;
            lrow_q          <= lrow_d;
            lcol_q          <= lcol_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

endmodule
